// File: rtl/pipe_sb_pkg.sv
// Shared definitions for the pipeline hazard scoreboard.
// Holds the default latency parameters, the per-source hazard result type,
// the latency clamp and the age-compare helper used by the flush logic.
package pipe_sb_pkg;

  localparam int SB_MAX_LAT = 4;
  localparam int SB_LATW    = 3;

  typedef struct packed {
    logic stall;
    logic fwd;
  } src_haz_t;

  // Map a requested latency into 1..max_lat. A request of 0 is taken as a
  // single-cycle result instead of being rejected.
  function automatic int unsigned clamp_lat(int unsigned lat, int unsigned max_lat);
    if (lat == 0) begin
      return 1;
    end else if (lat > max_lat) begin
      return max_lat;
    end
    return lat;
  endfunction

  // An entry is younger than the redirect point when its age is below the
  // flush threshold. Those entries belong to the wrong path.
  function automatic logic age_below(int unsigned age, int unsigned limit);
    return (age < limit);
  endfunction

endpackage

// File: rtl/pipe_scoreboard_entry.sv
// sb_entry: pending-write state for one architectural register.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   set_i, set_lat_i  start tracking a new write with normalised latency
//   flush_i, flush_age_i  kill this entry if it is younger than flush_age_i
//   pend_o, cnt_o     write pending; cycles left until the result is on the bypass
module sb_entry
  import pipe_sb_pkg::*;
#(
  parameter int LATW    = SB_LATW,
  parameter int MAX_LAT = SB_MAX_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_i,
  input  logic [LATW-1:0] set_lat_i,
  input  logic            flush_i,
  input  logic [LATW-1:0] flush_age_i,
  output logic            pend_o,
  output logic [LATW-1:0] cnt_o
);

  logic            pend_q, pend_d;
  logic [LATW-1:0] cnt_q, cnt_d;
  logic [LATW-1:0] age_q, age_d;

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    age_d  = age_q;
    if (flush_i && pend_q && age_below(32'(age_q), 32'(flush_age_i))) begin
      pend_d = 1'b0;
      cnt_d  = '0;
      age_d  = '0;
    end else if (set_i) begin
      // A new write replaces whatever was in flight for this register.
      pend_d = 1'b1;
      cnt_d  = set_lat_i;
      age_d  = '0;
    end else if (pend_q) begin
      // Surviving entries keep counting down, including in a flush cycle.
      cnt_d = cnt_q - LATW'(1);
      if (cnt_q == LATW'(1)) begin
        pend_d = 1'b0;
      end
      if (age_q != LATW'(MAX_LAT)) begin
        age_d = age_q + LATW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
      age_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
    end
  end

  assign pend_o = pend_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: per-register pending-write tracker between ID and issue.
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   issue_*                   instruction presented by ID (sources, dest, latency)
//   flush, flush_age          redirect; kills in-flight writes younger than flush_age
//   issue_stall               hold PC and IF/ID, bubble into ID/EX
//   fwd_rs, fwd_rt            source must take the bypass bus
//   pend_vec                  registered per-register pending flags
//   stall_cnt                 saturating count of stalled issue cycles
module pipe_scoreboard
  import pipe_sb_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int RW      = 5,
  parameter int MAX_LAT = SB_MAX_LAT,
  parameter int LATW    = SB_LATW,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_rs,
  input  logic [RW-1:0]   issue_rt,
  input  logic            issue_rs_used,
  input  logic            issue_rt_used,
  input  logic            issue_wen,
  input  logic [RW-1:0]   issue_wn,
  input  logic [LATW-1:0] issue_lat,
  input  logic            flush,
  input  logic [LATW-1:0] flush_age,
  output logic            issue_stall,
  output logic            fwd_rs,
  output logic            fwd_rt,
  output logic [NREG-1:0] pend_vec,
  output logic [CNTW-1:0] stall_cnt
);

  logic [NREG-1:0] pend_q;
  logic [LATW-1:0] cnt_q [NREG];
  logic [LATW-1:0] leff;
  logic            accept;
  logic            waw;
  src_haz_t        haz_a, haz_b;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  assign leff = LATW'(clamp_lat(32'(issue_lat), MAX_LAT));

  // Register 0 is never written, so its slot is tied off instead of tracked.
  assign pend_q[0] = 1'b0;
  assign cnt_q[0]  = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_ent
    sb_entry #(
      .LATW    (LATW),
      .MAX_LAT (MAX_LAT)
    ) u_ent (
      .clk         (clk),
      .rst         (rst),
      .set_i       (accept && (issue_wn == RW'(i))),
      .set_lat_i   (leff),
      .flush_i     (flush),
      .flush_age_i (flush_age),
      .pend_o      (pend_q[i]),
      .cnt_o       (cnt_q[i])
    );
  end

  // cnt==1 means the producer result is on the bypass bus this cycle.
  assign haz_a.stall = issue_rs_used && (issue_rs != '0) && pend_q[issue_rs]
                       && (cnt_q[issue_rs] > LATW'(1));
  assign haz_a.fwd   = issue_rs_used && (issue_rs != '0) && pend_q[issue_rs]
                       && (cnt_q[issue_rs] == LATW'(1));
  assign haz_b.stall = issue_rt_used && (issue_rt != '0) && pend_q[issue_rt]
                       && (cnt_q[issue_rt] > LATW'(1));
  assign haz_b.fwd   = issue_rt_used && (issue_rt != '0) && pend_q[issue_rt]
                       && (cnt_q[issue_rt] == LATW'(1));

  // A newer write must not complete at or before the older one to the same
  // register, otherwise the older result would land last.
  assign waw = issue_wen && (issue_wn != '0) && pend_q[issue_wn]
               && (cnt_q[issue_wn] > leff);

  // Gated by rst so the outputs read as idle while reset is held.
  assign issue_stall = rst && issue_valid && !flush
                       && (haz_a.stall || haz_b.stall || waw);
  assign fwd_rs      = rst && issue_valid && haz_a.fwd;
  assign fwd_rt      = rst && issue_valid && haz_b.fwd;

  assign accept = issue_valid && !issue_stall && !flush && issue_wen && (issue_wn != '0);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pend_vec  = pend_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_wn;
  logic        issue_rs_used, issue_rt_used, issue_wen;
  logic [2:0]  issue_lat;
  logic        flush;
  logic [2:0]  flush_age;
  logic        issue_stall, fwd_rs, fwd_rt;
  logic [31:0] pend_vec;
  logic [7:0]  stall_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  pipe_scoreboard #(.CNTW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_rs_used (issue_rs_used),
    .issue_rt_used (issue_rt_used),
    .issue_wen     (issue_wen),
    .issue_wn      (issue_wn),
    .issue_lat     (issue_lat),
    .flush         (flush),
    .flush_age     (flush_age),
    .issue_stall   (issue_stall),
    .fwd_rs        (fwd_rs),
    .fwd_rt        (fwd_rt),
    .pend_vec      (pend_vec),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rs = '0; issue_rt = '0;
    issue_rs_used = 1'b0; issue_rt_used = 1'b0;
    issue_wen = 1'b0; issue_wn = '0; issue_lat = '0;
    flush = 1'b0; flush_age = '0;
    #1;
  endtask

  // Present one instruction; flush is left untouched.
  task automatic drv(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                     input logic rtu, input logic wen, input logic [4:0] wn,
                     input logic [2:0] lat);
    issue_valid = 1'b1; issue_rs = rs; issue_rs_used = rsu;
    issue_rt = rt; issue_rt_used = rtu;
    issue_wen = wen; issue_wn = wn; issue_lat = lat;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // Reset held two cycles with a write presented
    rst = 1'b0;
    drv(0, 0, 0, 0, 1, 5, 2);
    step(); step();
    rst = 1'b1;
    idle();
    chk("rst_pend", pend_vec, 32'h0);
    chk("rst_scnt", 32'(stall_cnt), 0);
    drv(5, 1, 0, 0, 0, 0, 0);
    chk("rst_stall", 32'(issue_stall), 0);
    step(); idle();

    // RAW with L=3
    drv(0, 0, 0, 0, 1, 8, 3);
    chk("raw_issue", 32'(issue_stall), 0);
    step();
    drv(8, 1, 0, 0, 0, 0, 0);
    chk("raw_t1_stall", 32'(issue_stall), 1);
    chk("raw_t1_fwd", 32'(fwd_rs), 0);
    chk("raw_t1_pend", 32'(pend_vec[8]), 1);
    step();
    chk("raw_t2_stall", 32'(issue_stall), 1);
    step();
    chk("raw_t3_stall", 32'(issue_stall), 0);
    chk("raw_t3_fwd", 32'(fwd_rs), 1);
    step(); idle();
    chk("raw_pend_clr", 32'(pend_vec[8]), 0);
    chk("raw_scnt", 32'(stall_cnt), 2);

    // L=1 back-to-back
    drv(0, 0, 0, 0, 1, 4, 1);
    step();
    drv(0, 0, 4, 1, 0, 0, 0);
    chk("l1_stall", 32'(issue_stall), 0);
    chk("l1_fwd_rt", 32'(fwd_rt), 1);
    chk("l1_pend", 32'(pend_vec[4]), 1);
    step(); idle();
    chk("l1_pend_clr", 32'(pend_vec[4]), 0);

    // L=0 behaves as L=1
    drv(0, 0, 0, 0, 1, 7, 0);
    step();
    drv(7, 1, 0, 0, 0, 0, 0);
    chk("l0_stall", 32'(issue_stall), 0);
    chk("l0_fwd", 32'(fwd_rs), 1);
    step(); idle();

    // L=7 clamps to 4: three stall cycles then forward
    drv(0, 0, 0, 0, 1, 10, 7);
    step();
    drv(10, 1, 0, 0, 0, 0, 0);
    step(); step();
    chk("l7_t3_stall", 32'(issue_stall), 1);
    step();
    chk("l7_t4_stall", 32'(issue_stall), 0);
    chk("l7_t4_fwd", 32'(fwd_rs), 1);
    step(); idle();
    chk("l7_scnt", 32'(stall_cnt), 5);

    // WAW: L=4 then L=1 to the same register
    drv(0, 0, 0, 0, 1, 9, 4);
    step();
    drv(0, 0, 0, 0, 1, 9, 1);
    chk("waw_t1_stall", 32'(issue_stall), 1);
    step(); step();
    chk("waw_t3_stall", 32'(issue_stall), 1);
    step();
    chk("waw_t4_stall", 32'(issue_stall), 0);
    step();
    drv(9, 1, 0, 0, 0, 0, 0);
    chk("waw_new_fwd", 32'(fwd_rs), 1);
    chk("waw_new_pend", 32'(pend_vec[9]), 1);
    step(); idle();
    chk("waw_pend_clr", 32'(pend_vec[9]), 0);
    chk("waw_scnt", 32'(stall_cnt), 8);

    // Longer second writer is accepted immediately
    drv(0, 0, 0, 0, 1, 11, 1);
    step();
    drv(0, 0, 0, 0, 1, 11, 4);
    chk("waw_long_stall", 32'(issue_stall), 0);
    step(); idle();
    chk("waw_long_pend", 32'(pend_vec[11]), 1);
    step(); step(); step(); step();
    chk("waw_long_clr", 32'(pend_vec[11]), 0);

    // Flush: r3 older, r6 younger; issue in flush cycle dropped
    drv(0, 0, 0, 0, 1, 3, 4);
    step();
    drv(0, 0, 0, 0, 1, 6, 4);
    step();
    flush = 1'b1; flush_age = 3'd1;
    drv(3, 1, 0, 0, 1, 12, 2);
    chk("flush_no_stall", 32'(issue_stall), 0);
    step(); idle();
    chk("flush_r6", 32'(pend_vec[6]), 0);
    chk("flush_r3", 32'(pend_vec[3]), 1);
    chk("flush_r12", 32'(pend_vec[12]), 0);
    drv(3, 1, 0, 0, 0, 0, 0);
    chk("flush_r3_stall", 32'(issue_stall), 1);
    step();
    chk("flush_r3_fwd", 32'(fwd_rs), 1);
    step(); idle();
    chk("flush_scnt", 32'(stall_cnt), 9);

    // Register 0 is never tracked
    drv(0, 0, 0, 0, 1, 0, 4);
    chk("r0_wr_stall", 32'(issue_stall), 0);
    step();
    drv(0, 1, 0, 1, 0, 0, 0);
    chk("r0_rd_stall", 32'(issue_stall), 0);
    chk("r0_fwd_rs", 32'(fwd_rs), 0);
    chk("r0_fwd_rt", 32'(fwd_rt), 0);
    chk("r0_pend", pend_vec, 32'h0);
    step(); idle();

    // Saturation: each group is one accepted write plus three stalls
    for (int g = 0; g < 40; g++) begin
      drv(0, 0, 0, 0, 1, 13, 4);
      step();
      drv(13, 1, 0, 0, 0, 0, 0);
      step(); step(); step();
    end
    idle();
    chk("sat_mid", 32'(stall_cnt), 129);
    for (int g = 0; g < 50; g++) begin
      drv(0, 0, 0, 0, 1, 13, 4);
      step();
      drv(13, 1, 0, 0, 0, 0, 0);
      step(); step(); step();
    end
    idle();
    chk("sat_hold", 32'(stall_cnt), 255);
    step(); step();

    // Reset asserted with an entry in flight
    drv(0, 0, 0, 0, 1, 14, 4);
    step();
    rst = 1'b0;
    drv(14, 1, 0, 0, 0, 0, 0);
    chk("rst_mid_stall", 32'(issue_stall), 0);
    step();
    rst = 1'b1;
    idle();
    chk("rst_mid_pend", pend_vec, 32'h0);
    chk("rst_mid_scnt", 32'(stall_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised hazard scoreboard for the next-generation MIPS pipeline. It replaces the fixed single-stage hazard stall with per-register pending-write tracking.
- Supports functional units of variable latency, with forwarding, write-after-write (WAW) ordering and age-selective flush.
- Sits between ID and issue. ID presents source and destination registers; the block returns a stall and bypass selects, and keeps in-flight state until writeback.

Parameters:
- NREG, 32: number of architectural registers; register 0 is hard-wired zero.
- RW, 5: register-number width; must satisfy 2^RW >= NREG.
- MAX_LAT, 4: maximum result latency in cycles, minimum 1.
- LATW, 3: latency/age counter width; must satisfy 2^LATW > MAX_LAT.
- CNTW, 16: width of the stall performance counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous active-low reset.
- issue_valid, input, 1: ID presents an instruction this cycle.
- issue_rs, input, RW: source register A.
- issue_rt, input, RW: source register B.
- issue_rs_used, input, 1: source A is read.
- issue_rt_used, input, 1: source B is read.
- issue_wen, input, 1: instruction writes a register.
- issue_wn, input, RW: destination register.
- issue_lat, input, LATW: result latency in cycles, 1..MAX_LAT.
- flush, input, 1: branch/jump redirect.
- flush_age, input, LATW: kill entries with age < flush_age.
- issue_stall, output, 1: hold PC and IF/ID; insert a bubble into ID/EX.
- fwd_rs, output, 1: source A must use the bypass bus.
- fwd_rt, output, 1: source B must use the bypass bus.
- pend_vec, output, NREG: bit i set while register i has a pending write.
- stall_cnt, output, CNTW: count of stalled issue cycles, saturating.

Behaviour:
- Reset (rst==0 at a clk edge):
  - All pend, cnt and age cleared.
  - stall_cnt=0; pend_vec=0; issue_stall, fwd_rs and fwd_rt evaluate to 0.
  - Reset asserted mid-operation discards all in-flight entries in that same edge.
- Per-register state: pend (1 bit), cnt (LATW bits), age (LATW bits, saturating at MAX_LAT).
- Latency normalisation: Leff = 1 if issue_lat==0; MAX_LAT if issue_lat>MAX_LAT; otherwise issue_lat.
- Source hazard, combinational, for source A (source B is identical with rt):
  - Hazard exists when rs_used && rs!=0 && pend[rs].
  - cnt[rs]>1: RAW stall.
  - cnt[rs]==1: no stall, and fwd_rs=1.
- WAW hazard, combinational: stall when issue_wen && wn!=0 && pend[wn] && cnt[wn]>Leff.
  - Equal completion cycles are treated as a stall.
- issue_stall = issue_valid && !flush && (any RAW or WAW hazard). fwd_* are valid only while issue_valid.
- Accept condition: issue_valid && !issue_stall && !flush && issue_wen && wn!=0.
- Clocked update, priority highest first:
  1. reset.
  2. flush: clear entries with pend && age<flush_age; the issue in the flush cycle is dropped.
  3. accept: set pend[wn]=1, cnt[wn]=Leff, age[wn]=0. This overwrites any retiring or older entry for wn.
  4. Every other pend entry: cnt-=1, age+=1 (saturating); when cnt reaches 0, clear pend.
- Timing:
  - Issue at cycle t with L: cnt=L at t+1; forwarding is legal at t+L; pend clears at t+L+1.
  - L=1 never causes a dependent stall.
- stall_cnt increments on each cycle with issue_stall==1 and holds at 2^CNTW-1.
- Writes to register 0 are never tracked; reads of register 0 never stall or forward.
- pend_vec is driven directly from registers, with no combinational path from inputs.

Decomposition:
- Package pipe_sb_pkg holds MAX_LAT, LATW, the latency-clamp function and the age-compare helper.
- One sub-module, sb_entry: per-register pend/cnt/age with set, flush-kill and decrement. The top instantiates NREG-1 copies (indices 1..NREG-1) and adds the hazard muxes and the counter.

Test Plan:
- Reset: hold rst=0 for 2 cycles with issue_valid=1 and wn=5 -> pend_vec=0, stall_cnt=0, issue_stall=0 after release.
- RAW, L=3: issue wn=8 at t; reader rs=8 at t+1..t+3 -> stall at t+1 and t+2, fwd_rs=1 with no stall at t+3, stall_cnt=2.
- L=1 back-to-back: issue wn=4 (L=1) then rt=4 immediately -> no stall, fwd_rt=1, pend_vec[4] clear one cycle later.
- WAW: issue wn=9 (L=4); next cycle issue wn=9 (L=1) -> stall until cnt[9]<=1; a second writer with L=4 is accepted with no stall.
- Flush: issue r3 (L=4) at t, r6 (L=4) at t+1; flush with flush_age=1 at t+2 -> pend[6] cleared, pend[3] kept, issue in the flush cycle dropped.
- Register 0 and saturation: issue wn=0 or rs=0 -> never pend/stall; force 2^CNTW+5 stall cycles -> stall_cnt=2^CNTW-1.
